// File: rtl/bridge_pkg.sv
// Shared bridge definitions: device address map, timer register offsets,
// CTRL bit positions and the timer mode/state enums.
package bridge_pkg;

    localparam logic [31:0] BRIDGE_BASE = 32'h0000_3000;
    localparam logic [31:0] TIMER_BASE  = 32'h0000_7F00;
    localparam logic [31:0] TIMER_SPAN  = 32'h0000_0010;

    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    typedef enum logic {
        ONESHOT = 1'b0,
        RELOAD  = 1'b1
    } timer_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timer_state_t;

    // MODE encodings 2 and 3 behave as one-shot.
    function automatic timer_mode_t decode_mode(input logic [1:0] m);
        return (m == 2'd1) ? RELOAD : ONESHOT;
    endfunction

    function automatic logic is_timer_addr(input logic [31:0] a);
        return (a >= TIMER_BASE) && (a < TIMER_BASE + TIMER_SPAN);
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Prescaler for bridge_timer: emits one tick every PRESCALE cycles while
// run_i is high and restarts from zero whenever run_i drops.
module timer_tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic tick_o
);
    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (run_i && !tick_o) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/bridge_timer.sv
// Memory-mapped down-counter timer (CTRL/PRESET/COUNT) with one-shot and
// auto-reload modes. Define TIMER_PRESCALE_EN to count on prescaled ticks.
module bridge_timer
    import bridge_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
        $error("bridge_timer: WIDTH must be in 1..32");
    end
    if (PRESCALE < 1) begin : g_chk_prescale
        $error("bridge_timer: PRESCALE must be >= 1");
    end

    timer_state_t      state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  preset_q, preset_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              pending_q, pending_d;

    logic        en, im, tick, cnt_done, wr_ctrl, wr_preset;
    timer_mode_t mode;

    assign en        = ctrl_q[CTRL_EN];
    assign im        = ctrl_q[CTRL_IM];
    assign mode      = decode_mode(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);
    assign wr_ctrl   = we && (addr == TIMER_CTRL);
    assign wr_preset = we && (addr == TIMER_PRESET);

`ifdef TIMER_PRESCALE_EN
    timer_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .run_i  (state_q == CNT),
        .tick_o (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign cnt_done = (state_q == CNT) && en && tick && (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = LOAD;
            LOAD:    state_d = CNT;
            CNT:     if (!en) state_d = IDLE;
                     else if (cnt_done) state_d = INT;
            INT:     state_d = (mode == RELOAD) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pending is raised on entry to INT so the one-shot irq is already
    // visible during the INT cycle; set beats a same-cycle bus clear.
    always_comb begin
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;
        if (state_q == INT && mode == ONESHOT) ctrl_d[CTRL_EN] = 1'b0;
        if (wr_ctrl)   ctrl_d   = wdata[CTRL_W-1:0];
        if (wr_preset) preset_d = wdata[WIDTH-1:0];
        if (state_q == LOAD)
            count_d = preset_q;
        else if (state_q == CNT && en && tick && count_q != '0)
            count_d = count_q - WIDTH'(1);
        if (wr_ctrl || wr_preset)        pending_d = 1'b0;
        if (cnt_done && mode == ONESHOT) pending_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        irq = 1'b0;
        if (im) irq = (mode == ONESHOT) ? pending_q : (state_q == INT);
        rdata = '0;
        case (addr)
            TIMER_CTRL:   rdata = 32'(ctrl_q);
            TIMER_PRESET: rdata = 32'(preset_q);
            TIMER_COUNT:  rdata = 32'(count_q);
            default:      rdata = '0;
        endcase
    end
endmodule
